error_checker_ctrl: RTL and testbench
=====================================

ERROR_CHECKER_CTRL -- requirements
Module: error_checker_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: width of the sample address and sample count.
REQ-002 Parameter WORD_LEN, default 20: width of the error and threshold words.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a check pass; sampled only in IDLE.
REQ-006 sample_count  input  ADDR_W  number of samples N; 0 is legal; sampled when start is accepted.
REQ-007 threshold  input  WORD_LEN  unsigned error-magnitude limit; sampled when start is accepted.
REQ-008 error_bus  input  WORD_LEN  two's-complement error y - h(x) from the datapath.
REQ-009 mem_addr  output  ADDR_W  sample memory address for the x/y fetch.
REQ-010 mem_rd  output  1  sample memory read strobe; data appears on x_bus/y_bus the next cycle and is held until the next strobe.
REQ-011 h_x_ld  output  1  load enable for the datapath h(x) register.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at the end of a pass.
REQ-014 err_count  output  ADDR_W+1  number of samples with |error| > threshold.
REQ-015 max_err  output  WORD_LEN  largest |error| seen in the pass.
REQ-016 pass  output  1  high when err_count == 0 at the end of the pass.

Function
REQ-017 FSM states: IDLE, READ, LOAD, CHECK, FINISH; state is binary encoded.
REQ-018 IDLE: outputs mem_rd=0 and h_x_ld=0; start=1 latches N and threshold, clears index i, err_count, max_err and pass, then goes to READ if N>0, else to FINISH.
REQ-019 READ: mem_rd=1, mem_addr=i; next state LOAD.
REQ-020 LOAD: h_x_ld=1; next state CHECK.
REQ-021 CHECK: register mag = |error_bus|.
REQ-022 CHECK, threshold compare: if mag > threshold (strict), increment err_count.
REQ-023 CHECK, maximum: if mag > max_err, set max_err = mag.
REQ-024 CHECK, exit: if i == N-1 go to FINISH; otherwise increment i and go to READ.
REQ-025 FINISH: done=1 for exactly one cycle; pass <= (err_count == 0), using the value after the final CHECK update; next state IDLE.
REQ-026 Each sample takes 3 cycles.
REQ-027 With start accepted at edge t, done is high in cycle t+1+3N; for N=0, done is high in cycle t+1 with pass=1.
REQ-028 Magnitude: |e| = e for e >= 0 and -e otherwise, computed at WORD_LEN bits unsigned; -2^(WORD_LEN-1) maps to 2^(WORD_LEN-1) with no saturation.
REQ-029 err_count cannot overflow, because N <= 2^ADDR_W - 1.
REQ-030 start while busy is ignored, with no effect on the latched N or threshold.
REQ-031 start asserted in the same cycle as done is ignored; start is accepted only from IDLE on a later cycle.
REQ-032 err_count, max_err and pass hold their values from the end of a pass until the next accepted start or reset.
REQ-033 mem_addr holds its last value when mem_rd=0.
REQ-034 mem_rd and h_x_ld are never high in the same cycle.

Reset
REQ-035 rst=0 forces IDLE immediately, independent of clk.
REQ-036 rst=0 clears mem_addr, mem_rd, h_x_ld, busy, done, err_count, max_err, pass and i to 0.
REQ-037 Reset mid-pass aborts the pass with no done pulse; the first accepted start after rst rises begins a fresh pass.

Verification
REQ-038 N=0, start=1 -> busy=1 for 1 cycle, done at t+1, pass=1, err_count=0, max_err=0; mem_rd is never asserted.
REQ-039 N=3, threshold=0x00100, error_bus per CHECK = 0x00080, 0xFFE00, 0x00100 -> mem_addr 0,1,2; done at t+10; err_count=1; max_err=0x00200; pass=0.
REQ-040 N=2, threshold=0x7FFFF, error_bus = 0x80000 -> max_err=0x80000, err_count=2, pass=0.
REQ-041 rst low during the 2nd CHECK of an N=4 pass -> all outputs 0 immediately, no done pulse; a restart with N=1 and error 0 -> done at t+4, pass=1.
REQ-042 start pulsed every cycle during an N=2 pass -> exactly one done pulse at t+7; the results match a single pass; the start coincident with done is not accepted.

Source files
------------

// File: rtl/error_checker_ctrl.sv
// error_checker_ctrl: sequences sample fetch/load/check and tallies error magnitudes against a threshold.
module error_checker_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int WORD_LEN = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   sample_count,
  input  logic [WORD_LEN-1:0] threshold,
  input  logic [WORD_LEN-1:0] error_bus,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                h_x_ld,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     err_count,
  output logic [WORD_LEN-1:0] max_err,
  output logic                pass
);
  typedef enum logic [2:0] {IDLE, READ, LOAD, CHECK, FINISH} state_t;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  state_t state, state_nx;
  logic [ADDR_W-1:0]   n_q, i_q, addr_q;
  logic [WORD_LEN-1:0] thr_q, mag;
  logic                pass_q, last;
  assign mag  = error_bus[WORD_LEN-1] ? -error_bus : error_bus;
  assign last = i_q == n_q - IDX_ONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (sample_count != '0 ? READ : FINISH) : IDLE;
      READ:    state_nx = LOAD;
      LOAD:    state_nx = CHECK;
      CHECK:   state_nx = last ? FINISH : READ;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // pass is exposed live during the done cycle, then held from pass_q
  always_comb begin
    mem_rd   = state == READ;
    h_x_ld   = state == LOAD;
    busy     = state != IDLE;
    done     = state == FINISH;
    mem_addr = mem_rd ? i_q : addr_q;
    pass     = done ? (err_count == '0) : pass_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      n_q       <= '0;
      i_q       <= '0;
      addr_q    <= '0;
      thr_q     <= '0;
      err_count <= '0;
      max_err   <= '0;
      pass_q    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        n_q       <= sample_count;
        thr_q     <= threshold;
        i_q       <= '0;
        err_count <= '0;
        max_err   <= '0;
        pass_q    <= 1'b0;
      end
      if (state == READ) addr_q <= i_q;
      if (state == CHECK) begin
        if (mag > thr_q) err_count <= err_count + CNT_ONE;
        if (mag > max_err) max_err <= mag;
        if (!last) i_q <= i_q + IDX_ONE;
      end
      if (state == FINISH) pass_q <= err_count == '0;
    end
endmodule

// File: tb/tb_error_checker_ctrl.sv
// tb_error_checker_ctrl: vector table of check passes plus reset-abort and start-hammer sequences.
module tb_error_checker_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  sample_count = '0;
  logic [19:0] threshold = '0;
  logic [19:0] error_bus = '0;
  logic [7:0]  mem_addr;
  logic        mem_rd, h_x_ld, busy, done, pass;
  logic [8:0]  err_count;
  logic [19:0] max_err;
  logic [19:0] errs [4];
  int n_cmp = 0;
  int n_fail = 0;

  error_checker_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .sample_count(sample_count),
    .threshold(threshold), .error_bus(error_bus), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .h_x_ld(h_x_ld), .busy(busy), .done(done),
    .err_count(err_count), .max_err(max_err), .pass(pass)
  );

  always #5 clk = ~clk;

  // sample memory model: read strobe returns the error for that address next cycle
  always @(posedge clk) if (mem_rd) error_bus <= errs[mem_addr[1:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input int n, input logic [19:0] thr, input logic [19:0] e0, e1, e2,
                          input int cnt, input logic [19:0] mx, input bit ps);
    int rd = 0;
    int dcyc = -1;
    bit ok = 1'b1;
    errs[0] = e0; errs[1] = e1; errs[2] = e2; errs[3] = '0;
    step();
    start = 1'b1; sample_count = 8'(n); threshold = thr;
    step();
    start = 1'b0; sample_count = 8'hFF; threshold = '0;
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      if (mem_rd) begin
        if (mem_addr != 8'(rd)) ok = 1'b0;
        rd++;
      end
      if (mem_rd && h_x_ld) ok = 1'b0;
      if (done) dcyc = c;
      else step();
    end
    chk("done_cycle", dcyc, 1 + 3 * n);
    chk("busy_at_done", {31'b0, busy}, 1);
    chk("err_count", {23'b0, err_count}, cnt);
    chk("max_err", {12'b0, max_err}, {12'b0, mx});
    chk("pass", {31'b0, pass}, {31'b0, ps});
    chk("mem_rd_count", rd, n);
    chk("addr_seq", {31'b0, ok}, 1);
    step();
    chk("done_one_cycle", {31'b0, done}, 0);
    chk("busy_after", {31'b0, busy}, 0);
    chk("pass_hold", {31'b0, pass}, {31'b0, ps});
    chk("err_count_hold", {23'b0, err_count}, cnt);
    chk("max_err_hold", {12'b0, max_err}, {12'b0, mx});
  endtask

  typedef struct {
    int          n;
    logic [19:0] thr, e0, e1, e2;
    int          cnt;
    logic [19:0] mx;
    bit          ps;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dones, dc;
    logic [8:0]  hc;
    logic [19:0] hm;
    bit          hp;
    vecs[0] = '{0, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 0, 20'h00000, 1'b1};
    vecs[1] = '{3, 20'h00100, 20'h00080, 20'hFFE00, 20'h00100, 1, 20'h00200, 1'b0};
    vecs[2] = '{2, 20'h7FFFF, 20'h80000, 20'h80000, 20'h00000, 2, 20'h80000, 1'b0};
    vecs[3] = '{1, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 0, 20'h00000, 1'b1};
    vecs[4] = '{3, 20'h00005, 20'h00005, 20'hFFFFB, 20'h00003, 0, 20'h00005, 1'b1};
    vecs[5] = '{2, 20'h00000, 20'hFFFFF, 20'h00001, 20'h00000, 2, 20'h00001, 1'b0};
    errs[0] = '0; errs[1] = '0; errs[2] = '0; errs[3] = '0;
    step();
    step();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 0);
    chk("rst_err_count", {23'b0, err_count}, 0);
    chk("rst_pass", {31'b0, pass}, 0);
    rst = 1'b1;
    for (int k = 0; k < 6; k++)
      run_pass(vecs[k].n, vecs[k].thr, vecs[k].e0, vecs[k].e1, vecs[k].e2,
               vecs[k].cnt, vecs[k].mx, vecs[k].ps);
    // reset during the second CHECK of an N=4 pass
    errs[0] = 20'h00100; errs[1] = 20'h00100; errs[2] = 20'h00100; errs[3] = 20'h00100;
    step();
    start = 1'b1; sample_count = 8'd4; threshold = '0;
    step();
    start = 1'b0;
    for (int c = 1; c < 6; c++) step();
    chk("pre_rst_h_x_state", {31'b0, busy}, 1);
    chk("pre_rst_max_err", {12'b0, max_err}, 32'h100);
    rst = 1'b0;
    #1;
    chk("abort_mem_addr", {24'b0, mem_addr}, 0);
    chk("abort_mem_rd", {31'b0, mem_rd}, 0);
    chk("abort_h_x_ld", {31'b0, h_x_ld}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_err_count", {23'b0, err_count}, 0);
    chk("abort_max_err", {12'b0, max_err}, 0);
    chk("abort_pass", {31'b0, pass}, 0);
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done) dones++;
    end
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_pass(1, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 0, 20'h00000, 1'b1);
    // start held high through an N=2 pass, with junk on the latched inputs while busy
    errs[0] = 20'h00003; errs[1] = 20'h00000; errs[2] = '0; errs[3] = '0;
    step();
    start = 1'b1; sample_count = 8'd2; threshold = '0;
    step();
    sample_count = 8'd1; threshold = 20'hFFFFF;
    dones = 0; dc = -1; hc = '0; hm = '0; hp = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (done) begin
        dones++;
        dc = c;
        hc = err_count; hm = max_err; hp = pass;
      end
      if (c == 8) begin
        chk("hammer_idle_after_done", {31'b0, busy}, 0);
        start = 1'b0;
      end
      step();
    end
    chk("hammer_done_count", dones, 1);
    chk("hammer_done_cycle", dc, 7);
    chk("hammer_err_count", {23'b0, hc}, 1);
    chk("hammer_max_err", {12'b0, hm}, 3);
    chk("hammer_pass", {31'b0, hp}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
